fuzz_stim_sequencer: RTL and testbench



---
 rtl/fuzz_stim_sequencer_if.sv | 26 ++
 rtl/fuzz_stim_sequencer.sv | 157 +++++++++++++++
 tb/tb_fuzz_stim_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fuzz_stim_sequencer_if.sv
// Stimulus/response bundle between the fuzz sequencer and its controller/DUT side.
// The master side issues run requests and returns DUT responses; the sequencer is the slave.
interface fuzz_stim_sequencer_if #(
  parameter int IN_W  = 137,
  parameter int OUT_W = 159
);
  logic             start;
  logic [31:0]      seed_i;
  logic [31:0]      cycles_i;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [31:0]      cyc_cnt;
  logic [31:0]      signature;

  modport master (
    output start, seed_i, cycles_i, dut_out,
    input  dut_in, busy, done, cyc_cnt, signature
  );

  modport slave (
    input  start, seed_i, cycles_i, dut_out,
    output dut_in, busy, done, cyc_cnt, signature
  );
endinterface

// File: rtl/fuzz_stim_sequencer.sv
// Hardware LCG stimulus sequencer with rotate-XOR response compactor for the fuzz harness.
// One vector per cycle from a seeded LCG chain; every response sample folds into a 32-bit signature.
module fuzz_stim_sequencer #(
  parameter int IN_W  = 137,
  parameter int OUT_W = 159
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fuzz_stim_sequencer_if.slave   bus
);
  localparam int NCH    = (IN_W + 31) / 32;
  localparam int NCH_O  = (OUT_W + 31) / 32;
  localparam int LAST_W = IN_W - 32 * (NCH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic              accept_s;
  logic              load_s;
  logic              sample_s;
  logic              dec_s;
  logic              done_s;

  logic [31:0]       rng_r;
  logic [31:0]       remaining_r;
  logic [IN_W-1:0]   dut_in_r;
  logic              busy_r;
  logic              done_r;
  logic [31:0]       cyc_cnt_r;
  logic [31:0]       signature_r;

  logic [IN_W-1:0]     vec_s;
  logic [31:0]         rng_next_s;
  logic [NCH_O*32-1:0] out_pad_s;
  logic [31:0]         fold_s;

  function automatic logic [31:0] lcg_step(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h00003039;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic and per-state datapath strobes
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    load_s       = 1'b0;
    sample_s     = 1'b0;
    dec_s        = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          accept_s     = 1'b1;
          next_state_s = INIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      INIT: begin
        load_s       = 1'b1;
        next_state_s = SETTLE;
      end
      SETTLE: begin
        sample_s = 1'b1;
        if (remaining_r == 32'd0) next_state_s = DRAIN;
        else                      next_state_s = RUN;
      end
      RUN: begin
        sample_s = 1'b1;
        load_s   = 1'b1;
        dec_s    = 1'b1;
        if (remaining_r == 32'd1) next_state_s = DRAIN;
        else                      next_state_s = RUN;
      end
      DRAIN: begin
        sample_s     = 1'b1;
        done_s       = 1'b1;
        next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // NCH chained LCG steps in one cycle; the final state also reseeds rng
  always_comb begin
    logic [31:0] acc;
    acc   = rng_r;
    vec_s = '0;
    for (int k = 0; k < NCH - 1; k++) begin
      acc = lcg_step(acc);
      vec_s[k*32 +: 32] = acc;
    end
    acc = lcg_step(acc);
    vec_s[IN_W-1 -: LAST_W] = acc[LAST_W-1:0];
    rng_next_s = acc;
  end

  // XOR of all 32-bit response slices, top slice zero-padded
  always_comb begin
    out_pad_s = '0;
    out_pad_s[OUT_W-1:0] = bus.dut_out;
    fold_s = 32'd0;
    for (int k = 0; k < NCH_O; k++) begin
      fold_s = fold_s ^ out_pad_s[k*32 +: 32];
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rng_r       <= 32'd0;
      remaining_r <= 32'd0;
      dut_in_r    <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cyc_cnt_r   <= 32'd0;
      signature_r <= 32'd0;
    end else begin
      if (accept_s) begin
        rng_r       <= bus.seed_i;
        remaining_r <= bus.cycles_i;
        signature_r <= 32'd0;
        cyc_cnt_r   <= 32'd0;
      end else begin
        if (load_s) begin
          dut_in_r <= vec_s;
          rng_r    <= rng_next_s;
        end
        if (dec_s) remaining_r <= remaining_r - 32'd1;
        if (sample_s) begin
          signature_r <= {signature_r[30:0], signature_r[31]} ^ fold_s;
          cyc_cnt_r   <= cyc_cnt_r + 32'd1;
        end
      end
      busy_r <= (next_state_s != IDLE);
      done_r <= done_s;
    end
  end

  assign bus.dut_in    = dut_in_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.cyc_cnt   = cyc_cnt_r;
  assign bus.signature = signature_r;
endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Directed self-checking bench for fuzz_stim_sequencer: LCG vectors, run timing, signature fold,
// start filtering and mid-run reset.
module tb_fuzz_stim_sequencer;
  localparam int IN_W  = 137;
  localparam int OUT_W = 159;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fuzz_stim_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fuzz_stim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [IN_W-1:0] first_vec;

  task automatic check_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h00003039;
  endfunction

  function automatic logic [IN_W-1:0] model_vec(input logic [31:0] rng_in, output logic [31:0] rng_out);
    logic [159:0] v;
    logic [31:0]  s;
    s = rng_in;
    v = '0;
    for (int k = 0; k < 5; k++) begin
      s = lcg(s);
      v[k*32 +: 32] = s;
    end
    rng_out = s;
    return v[IN_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] pattern(input int e);
    logic [159:0] p;
    logic [31:0]  s;
    s = 32'hA5A50000 ^ 32'(e);
    for (int k = 0; k < 5; k++) begin
      s = (s * 32'h01000193) ^ 32'h9E3779B9;
      p[k*32 +: 32] = s;
    end
    return p[OUT_W-1:0];
  endfunction

  function automatic logic [31:0] fold(input logic [OUT_W-1:0] d);
    logic [159:0] p;
    p = '0;
    p[OUT_W-1:0] = d;
    return p[31:0] ^ p[63:32] ^ p[95:64] ^ p[127:96] ^ p[159:128];
  endfunction

  task automatic check_zero(input string tag);
    check_eq({tag, " dut_in"}, 160'(bus.dut_in), 160'd0);
    check_eq({tag, " busy"}, 160'(bus.busy), 160'd0);
    check_eq({tag, " done"}, 160'(bus.done), 160'd0);
    check_eq({tag, " cyc_cnt"}, 160'(bus.cyc_cnt), 160'd0);
    check_eq({tag, " signature"}, 160'(bus.signature), 160'd0);
  endtask

  // One run: start at E0, then walk every edge checking vectors, busy and done timing.
  task automatic run(input logic [31:0] seed, input int cycles, input bit drive_out,
                     input int poke_at, input int rst_at, input bit chain);
    logic [31:0]      rng;
    logic [31:0]      rng_n;
    logic [31:0]      sig;
    logic [IN_W-1:0]  vec;
    logic [OUT_W-1:0] out_v;
    int               last;
    last = cycles + 3;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.seed_i   = seed;
    bus.cycles_i = 32'(cycles);
    bus.dut_out  = '0;
    @(posedge clk);
    #1;
    check_eq("busy after start", 160'(bus.busy), 160'd1);
    rng = seed;
    sig = 32'd0;
    vec = '0;
    for (int e = 1; e <= (chain ? last : last + 1); e++) begin
      @(negedge clk);
      bus.start    = (e == poke_at);
      bus.seed_i   = 32'hDEADBEEF;
      bus.cycles_i = 32'd3;
      out_v        = drive_out ? pattern(e) : '0;
      bus.dut_out  = out_v;
      if (e == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("async reset");
        @(posedge clk);
        #1;
        check_zero("held reset");
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        return;
      end
      @(posedge clk);
      if (e == 1 || (e >= 3 && e <= cycles + 2)) begin
        vec = model_vec(rng, rng_n);
        rng = rng_n;
      end
      if (e == 1) first_vec = vec;
      if (e >= 2 && e <= last) sig = {sig[30:0], sig[31]} ^ fold(out_v);
      #1;
      check_eq($sformatf("dut_in e%0d", e), 160'(bus.dut_in), 160'(vec));
      check_eq($sformatf("done e%0d", e), 160'(bus.done), 160'(e == last));
      check_eq($sformatf("busy e%0d", e), 160'(bus.busy), 160'(e < last));
    end
    check_eq("cyc_cnt", 160'(bus.cyc_cnt), 160'(32'(cycles + 2)));
    check_eq("signature", 160'(bus.signature), 160'(sig));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.seed_i   = 32'd0;
    bus.cycles_i = 32'd0;
    bus.dut_out  = '0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_zero("idle");

    run(32'd0, 0, 1'b0, -1, -1, 1'b0);
    check_eq("seed0 chunk0", 160'(bus.dut_in[31:0]), 160'(32'h00003039));
    check_eq("seed0 signature", 160'(bus.signature), 160'd0);

    run(32'd1, 5, 1'b0, -1, -1, 1'b0);
    check_eq("seed1 chunk0", 160'(first_vec[31:0]), 160'(32'h41C67EA6));

    run(32'h8C25166A, 100, 1'b1, -1, -1, 1'b0);

    run(32'd7, 10, 1'b1, 5, -1, 1'b1);
    run(32'd9, 3, 1'b1, -1, -1, 1'b0);

    run(32'd1, 50, 1'b1, -1, 21, 1'b0);
    run(32'd1, 5, 1'b0, -1, -1, 1'b0);
    check_eq("post-reset seed1 chunk0", 160'(first_vec[31:0]), 160'(32'h41C67EA6));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
